ctrl_fsm: RTL and testbench

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_fsm_pkg.sv | 60 ++++++
 rtl/ctrl_decode.sv | 25 ++
 rtl/ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_ctrl_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm_pkg: shared definitions for the instruction sequencer.
//   ctrl_state_t   sequencer states
//   op_mne         4-bit opcode map (IR[8:5])
//   dec_t          per-opcode enables produced by ctrl_decode
//   IR field positions and the illegal opcode range
package ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_XOR = 4'h1,
        OP_GST = 4'h2,
        OP_LSB = 4'h3,
        OP_MSB = 4'h4,
        OP_LRS = 4'h5,
        OP_ENQ = 4'h6,
        OP_EQI = 4'h7,
        OP_ACC = 4'h8,
        OP_LDS = 4'h9,
        OP_BRC = 4'hA,
        OP_BRR = 4'hB,
        OP_IL0 = 4'hC,
        OP_IL1 = 4'hD,
        OP_IL2 = 4'hE,
        OP_RST = 4'hF
    } op_mne;

    // Instruction field positions
    localparam int unsigned OPC_MSB  = 8;
    localparam int unsigned OPC_LSB  = 5;
    localparam int unsigned FUNC_BIT = 4;
    localparam int unsigned OPND_MSB = 3;
    localparam int unsigned OPND_LSB = 0;

    // Reserved opcode range
    localparam logic [3:0] ILL_LO = 4'hC;
    localparam logic [3:0] ILL_HI = 4'hE;

    typedef struct packed {
        logic regWe;    // register-file write in EXEC
        logic accWe;    // accumulator write in EXEC
        logic toMem;    // continue into MEM
        logic brCond;   // relative branch on br_flag
        logic brReg;    // register branch on br_flag
        logic halt;     // stop sequencing
        logic illegal;  // reserved opcode
    } dec_t;

    function automatic logic isIllegalOp(input logic [3:0] opc);
        return (opc >= ILL_LO) && (opc <= ILL_HI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode-to-enable decoder.
//   opcode  in   op_mne  opcode field of the instruction being decoded
//   dec     out  dec_t   enables / sequencing hints for that opcode
module ctrl_decode
    import ctrl_fsm_pkg::*;
(
    input  op_mne opcode,
    output dec_t  dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD, OP_XOR, OP_GST, OP_LSB,
            OP_MSB, OP_LRS, OP_ENQ, OP_EQI: dec.regWe  = 1'b1;
            OP_ACC:                         dec.accWe  = 1'b1;
            OP_LDS:                         dec.toMem  = 1'b1;
            OP_BRC:                         dec.brCond = 1'b1;
            OP_BRR:                         dec.brReg  = 1'b1;
            OP_RST:                         dec.halt   = 1'b1;
            default:                        dec.illegal = isIllegalOp(opcode);
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: fetch/execute sequencer with program counter.
//   Clk, Reset_n           clock, asynchronous active-low reset
//   start                  begin at pc=0 from IDLE or HALT
//   instr, instr_valid     instruction word and its valid strobe (FETCH only)
//   fetch_req, pc          instruction request at current pc
//   alu_op, func, operand  IR fields, driven in EXEC and MEM, else 0
//   reg_we, acc_we         register-file / accumulator write enables
//   mem_req, mem_we        data-memory request and write qualifier
//   mem_ack                data-memory completion
//   br_flag, br_target     branch condition and BRR target
//   done, illegal          halted indicator, reserved-opcode pulse
module ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int unsigned IW  = 9,
    parameter int unsigned PCW = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           start,
    input  logic [IW-1:0]  instr,
    input  logic           instr_valid,
    output logic           fetch_req,
    output logic [PCW-1:0] pc,
    output op_mne          alu_op,
    output logic           func,
    output logic [3:0]     operand,
    output logic           reg_we,
    output logic           acc_we,
    output logic           mem_req,
    output logic           mem_we,
    input  logic           mem_ack,
    input  logic           br_flag,
    input  logic [PCW-1:0] br_target,
    output logic           done,
    output logic           illegal
);

    localparam logic [PCW-1:0] PC_ONE = PCW'(1);

    ctrl_state_t    state;
    logic [IW-1:0]  ir;
    logic           regWeQ;
    op_mne          decIn;
    dec_t           dec;
    logic [PCW-1:0] pcInc;
    logic [PCW-1:0] brOffset;
    logic [PCW-1:0] pcNext;
    logic           memLoadDone;

    // In FETCH the incoming word is decoded so EXEC-cycle enables can be
    // registered on the FETCH->EXEC edge; elsewhere the IR is decoded.
    assign decIn = (state == ST_FETCH) ? op_mne'(instr[OPC_MSB:OPC_LSB])
                                       : op_mne'(ir[OPC_MSB:OPC_LSB]);

    ctrl_decode uDecode (
        .opcode (decIn),
        .dec    (dec)
    );

    always_comb begin
        pcInc    = pc + PC_ONE;
        brOffset = {{(PCW-4){ir[OPND_MSB]}}, ir[OPND_MSB:OPND_LSB]};
        pcNext   = pcInc;
        if (dec.brCond && br_flag) begin
            pcNext = pc + brOffset;
        end else if (dec.brReg && br_flag) begin
            pcNext = br_target;
        end
    end

    // The load write-back must coincide with the mem_ack cycle itself,
    // so it is the one enable not taken from a register.
    assign memLoadDone = (state == ST_MEM) && mem_ack && !ir[FUNC_BIT];
    assign reg_we      = regWeQ | memLoadDone;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            ir        <= '0;
            fetch_req <= 1'b0;
            alu_op    <= OP_ADD;
            func      <= 1'b0;
            operand   <= '0;
            regWeQ    <= 1'b0;
            acc_we    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            regWeQ  <= 1'b0;
            acc_we  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_FETCH;
                        pc        <= '0;
                        fetch_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        state     <= ST_EXEC;
                        ir        <= instr;
                        fetch_req <= 1'b0;
                        alu_op    <= op_mne'(instr[OPC_MSB:OPC_LSB]);
                        func      <= instr[FUNC_BIT];
                        operand   <= instr[OPND_MSB:OPND_LSB];
                        regWeQ    <= dec.regWe;
                        acc_we    <= dec.accWe;
                        illegal   <= dec.illegal;
                    end
                end
                ST_EXEC: begin
                    if (dec.toMem) begin
                        state   <= ST_MEM;
                        mem_req <= 1'b1;
                        mem_we  <= ir[FUNC_BIT];
                    end else begin
                        alu_op  <= OP_ADD;
                        func    <= 1'b0;
                        operand <= '0;
                        if (dec.halt) begin
                            state <= ST_HALT;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_FETCH;
                            fetch_req <= 1'b1;
                            pc        <= pcNext;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state     <= ST_FETCH;
                        fetch_req <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        alu_op    <= OP_ADD;
                        func      <= 1'b0;
                        operand   <= '0;
                        pc        <= pcInc;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state     <= ST_FETCH;
                        fetch_req <= 1'b1;
                        done      <= 1'b0;
                        pc        <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed self-checking bench for ctrl_fsm.
module tb_ctrl_fsm;
    import ctrl_fsm_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic       start;
    logic [8:0] instr;
    logic       instr_valid;
    logic       fetch_req;
    logic [7:0] pc;
    op_mne      alu_op;
    logic       func;
    logic [3:0] operand;
    logic       reg_we;
    logic       acc_we;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack;
    logic       br_flag;
    logic [7:0] br_target;
    logic       done;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    ctrl_fsm #(.IW(9), .PCW(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .instr(instr),
        .instr_valid(instr_valid), .fetch_req(fetch_req), .pc(pc),
        .alu_op(alu_op), .func(func), .operand(operand), .reg_we(reg_we),
        .acc_we(acc_we), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .br_flag(br_flag), .br_target(br_target), .done(done), .illegal(illegal)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents one instruction in FETCH; returns #1 after the edge into EXEC.
    task automatic issue(input logic [8:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; start = 1'b0; instr = '0; instr_valid = 1'b0;
        mem_ack = 1'b0; br_flag = 1'b0; br_target = '0;
        #12;
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_fetch_req: got %0b expected 0", fetch_req); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %0h expected 0", pc); end
        checks++; if ({reg_we, acc_we, mem_req, mem_we, done, illegal} !== 6'b0) begin errors++; $display("FAIL rst_outputs: got %0b expected 0", {reg_we, acc_we, mem_req, mem_we, done, illegal}); end
        Reset_n = 1'b1;
        tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL idle_no_start: got %0b expected 0", fetch_req); end
    endtask

    task automatic test_add();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (fetch_req !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL start_fetch: got req=%0b pc=%0h expected req=1 pc=0", fetch_req, pc); end
        issue(9'b0_0000_0011);
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL add_reg_we: got %0b expected 1", reg_we); end
        checks++; if (operand !== 4'd3 || alu_op !== OP_ADD) begin errors++; $display("FAIL add_fields: got op=%0h opnd=%0h expected op=0 opnd=3", alu_op, operand); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL add_exec_fetch: got %0b expected 0", fetch_req); end
        tick();
        checks++; if (reg_we !== 1'b0 || operand !== 4'd0) begin errors++; $display("FAIL add_after: got we=%0b opnd=%0h expected 0 0", reg_we, operand); end
        checks++; if (pc !== 8'h01 || fetch_req !== 1'b1) begin errors++; $display("FAIL add_pc: got pc=%0h req=%0b expected pc=1 req=1", pc, fetch_req); end
    endtask

    task automatic test_load_store();
        int reqCycles = 0;
        issue({4'h9, 1'b0, 4'h2});
        checks++; if (reg_we !== 1'b0 || mem_req !== 1'b0 || alu_op !== OP_LDS) begin errors++; $display("FAIL lds_exec: got we=%0b req=%0b op=%0h expected 0 0 9", reg_we, mem_req, alu_op); end
        tick();
        for (int k = 0; k < 4; k++) begin
            if (mem_req === 1'b1) reqCycles++;
            checks++; if (mem_we !== 1'b0 || alu_op !== OP_LDS) begin errors++; $display("FAIL lds_mem_we: got we=%0b op=%0h expected 0 9", mem_we, alu_op); end
            if (k == 3) mem_ack = 1'b1;
            #1;
            checks++; if (reg_we !== (k == 3)) begin errors++; $display("FAIL lds_reg_we_%0d: got %0b expected %0b", k, reg_we, (k == 3)); end
            tick();
            mem_ack = 1'b0;
        end
        checks++; if (reqCycles != 4) begin errors++; $display("FAIL lds_req_cycles: got %0d expected 4", reqCycles); end
        checks++; if (mem_req !== 1'b0 || reg_we !== 1'b0 || pc !== 8'h02) begin errors++; $display("FAIL lds_done: got req=%0b we=%0b pc=%0h expected 0 0 2", mem_req, reg_we, pc); end
        issue({4'h9, 1'b1, 4'h5});
        tick();
        mem_ack = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || reg_we !== 1'b0 || func !== 1'b1) begin errors++; $display("FAIL store_mem: got req=%0b we=%0b rwe=%0b func=%0b expected 1 1 0 1", mem_req, mem_we, reg_we, func); end
        tick();
        mem_ack = 1'b0;
        checks++; if (pc !== 8'h03 || mem_req !== 1'b0) begin errors++; $display("FAIL store_done: got pc=%0h req=%0b expected 3 0", pc, mem_req); end
    endtask

    task automatic test_branch();
        issue(9'h000); tick();
        issue(9'h000); tick();
        checks++; if (pc !== 8'h05) begin errors++; $display("FAIL br_setup: got %0h expected 5", pc); end
        br_flag = 1'b1;
        issue({4'hA, 1'b0, 4'b1110});
        checks++; if (reg_we !== 1'b0 || acc_we !== 1'b0) begin errors++; $display("FAIL brc_nowrite: got %0b%0b expected 00", reg_we, acc_we); end
        tick();
        checks++; if (pc !== 8'h03) begin errors++; $display("FAIL brc_taken: got %0h expected 3", pc); end
        br_flag = 1'b0;
        issue(9'h000); tick();
        issue(9'h000); tick();
        issue({4'hA, 1'b0, 4'b1110}); tick();
        checks++; if (pc !== 8'h06) begin errors++; $display("FAIL brc_not_taken: got %0h expected 6", pc); end
        br_flag = 1'b1; br_target = 8'hA0;
        issue({4'hB, 1'b0, 4'h0}); tick();
        checks++; if (pc !== 8'hA0) begin errors++; $display("FAIL brr_taken: got %0h expected a0", pc); end
        br_flag = 1'b0;
    endtask

    task automatic test_wrap_illegal();
        br_flag = 1'b1; br_target = 8'hFF;
        issue({4'hB, 1'b0, 4'h0}); tick();
        br_flag = 1'b0;
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_setup: got %0h expected ff", pc); end
        issue({4'h1, 1'b0, 4'h7});
        checks++; if (reg_we !== 1'b1 || alu_op !== OP_XOR) begin errors++; $display("FAIL xor_exec: got we=%0b op=%0h expected 1 1", reg_we, alu_op); end
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap_up: got %0h expected 0", pc); end
        br_flag = 1'b1;
        issue({4'hA, 1'b0, 4'b1111}); tick();
        br_flag = 1'b0;
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL pc_wrap_down: got %0h expected ff", pc); end
        issue({4'hD, 1'b0, 4'h0});
        checks++; if (illegal !== 1'b1 || reg_we !== 1'b0 || acc_we !== 1'b0) begin errors++; $display("FAIL illegal_exec: got ill=%0b we=%0b acc=%0b expected 1 0 0", illegal, reg_we, acc_we); end
        tick();
        checks++; if (illegal !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL illegal_after: got ill=%0b pc=%0h expected 0 0", illegal, pc); end
        issue({4'h8, 1'b0, 4'h1});
        checks++; if (acc_we !== 1'b1 || reg_we !== 1'b0) begin errors++; $display("FAIL acc_exec: got acc=%0b we=%0b expected 1 0", acc_we, reg_we); end
        tick();
        checks++; if (acc_we !== 1'b0 || pc !== 8'h01) begin errors++; $display("FAIL acc_after: got acc=%0b pc=%0h expected 0 1", acc_we, pc); end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++; if (pc !== 8'h01 || fetch_req !== 1'b1) begin errors++; $display("FAIL start_in_fetch: got pc=%0h req=%0b expected 1 1", pc, fetch_req); end
    endtask

    task automatic test_halt();
        int doneCycles = 0;
        issue({4'hF, 1'b0, 4'h0});
        checks++; if (done !== 1'b0 || reg_we !== 1'b0) begin errors++; $display("FAIL rst_op_exec: got done=%0b we=%0b expected 0 0", done, reg_we); end
        tick();
        checks++; if (done !== 1'b1 || fetch_req !== 1'b0 || pc !== 8'h01) begin errors++; $display("FAIL halt_entry: got done=%0b req=%0b pc=%0h expected 1 0 1", done, fetch_req, pc); end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done === 1'b1) doneCycles++;
        end
        checks++; if (doneCycles != 10) begin errors++; $display("FAIL halt_hold: got %0d expected 10", doneCycles); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b0 || fetch_req !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL halt_restart: got done=%0b req=%0b pc=%0h expected 0 1 0", done, fetch_req, pc); end
    endtask

    task automatic test_reset_mid_mem();
        issue({4'h9, 1'b0, 4'h0});
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_setup: got %0b expected 1", mem_req); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || fetch_req !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL async_reset: got req=%0b freq=%0b pc=%0h expected 0 0 0", mem_req, fetch_req, pc); end
        start = 1'b1;
        tick();
        tick();
        checks++; if (fetch_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_in_reset: got req=%0b done=%0b expected 0 0", fetch_req, done); end
        start = 1'b0;
        Reset_n = 1'b1;
        tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0b expected 0", fetch_req); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (fetch_req !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL post_reset_start: got req=%0b pc=%0h expected 1 0", fetch_req, pc); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_store();
        test_branch();
        test_wrap_illegal();
        test_start_ignored();
        test_halt();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
